alu_seq: RTL and testbench



---
 rtl/alu_seq.sv | 185 ++++++++++++++++++
 tb/tb_alu_seq.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Handshaked sequential ALU: registered single-cycle ops plus iterative multiply and divide.
// Define ALU_SEQ_DIV_EN to build the restoring divider (DIVU/REMU); otherwise they are reserved.
module alu_seq #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned SHAMT_LSB = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       ALU_operation,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] res,
    output logic             zero,
    output logic             ovf,
    output logic             dbz
);
    localparam int unsigned SW = $clog2(WIDTH);

    localparam logic [3:0] OpAnd   = 4'b0000;
    localparam logic [3:0] OpOr    = 4'b0001;
    localparam logic [3:0] OpAdd   = 4'b0010;
    localparam logic [3:0] OpXor   = 4'b0011;
    localparam logic [3:0] OpNor   = 4'b0100;
    localparam logic [3:0] OpSrl   = 4'b0101;
    localparam logic [3:0] OpSub   = 4'b0110;
    localparam logic [3:0] OpSlt   = 4'b0111;
    localparam logic [3:0] OpSll   = 4'b1000;
    localparam logic [3:0] OpSra   = 4'b1001;
    localparam logic [3:0] OpSltu  = 4'b1010;
    localparam logic [3:0] OpMul   = 4'b1011;
    localparam logic [3:0] OpMulhu = 4'b1100;
`ifdef ALU_SEQ_DIV_EN
    localparam logic [3:0] OpDivu  = 4'b1101;
    localparam logic [3:0] OpRemu  = 4'b1110;
`endif

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e           r_state;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_res;
    logic             r_zero, r_ovf, r_dbz;
    logic [WIDTH-1:0] r_hi, r_lo, r_m;
    logic [3:0]       r_op;
    logic [SW-1:0]    r_cnt;

    logic [SW-1:0]    w_shamt;
    logic [WIDTH-1:0] w_sum, w_diff, w_res;
    logic             w_ovf, w_accept, w_multi, w_in_div, w_op_div;
    logic [WIDTH:0]   w_madd;
    logic [WIDTH-1:0] w_hi_nx, w_lo_nx, w_fin;
    logic             w_fin_dbz;

    assign in_ready  = (r_state == StIdle) || ((r_state == StDone) && out_ready);
    assign w_accept  = in_valid && in_ready;
    assign out_valid = r_out_valid;
    assign res       = r_res;
    assign zero      = r_zero;
    assign ovf       = r_ovf;
    assign dbz       = r_dbz;
    assign w_shamt   = B[SHAMT_LSB +: SW];

`ifdef ALU_SEQ_DIV_EN
    assign w_in_div = (ALU_operation == OpDivu) || (ALU_operation == OpRemu);
    assign w_op_div = (r_op == OpDivu) || (r_op == OpRemu);
`else
    assign w_in_div = 1'b0;
    assign w_op_div = 1'b0;
`endif
    assign w_multi = (ALU_operation == OpMul) || (ALU_operation == OpMulhu) || w_in_div;

    always_comb begin
        w_sum  = A + B;
        w_diff = A - B;
        w_res  = '0;
        w_ovf  = 1'b0;
        case (ALU_operation)
            OpAnd:  w_res = A & B;
            OpOr:   w_res = A | B;
            OpAdd: begin
                w_res = w_sum;
                w_ovf = (A[WIDTH-1] == B[WIDTH-1]) && (w_sum[WIDTH-1] != A[WIDTH-1]);
            end
            OpXor:  w_res = A ^ B;
            OpNor:  w_res = ~(A | B);
            OpSrl:  w_res = A >> w_shamt;
            OpSub: begin
                w_res = w_diff;
                w_ovf = (A[WIDTH-1] != B[WIDTH-1]) && (w_diff[WIDTH-1] != A[WIDTH-1]);
            end
            OpSlt:  w_res = {{(WIDTH-1){1'b0}}, $signed(A) < $signed(B)};
            OpSll:  w_res = A << w_shamt;
            OpSra:  w_res = $signed(A) >>> w_shamt;
            OpSltu: w_res = {{(WIDTH-1){1'b0}}, A < B};
            default: w_res = '0;
        endcase
    end

    // One iteration: multiply shifts {hi,lo} right, divide shifts the remainder left.
`ifdef ALU_SEQ_DIV_EN
    logic [WIDTH:0]   w_shift;
    logic [WIDTH-1:0] w_sub;
`endif
    always_comb begin
        w_madd = {1'b0, r_hi} + {1'b0, r_m};
        if (r_lo[0]) begin
            {w_hi_nx, w_lo_nx} = {w_madd, r_lo[WIDTH-1:1]};
        end else begin
            {w_hi_nx, w_lo_nx} = {1'b0, r_hi, r_lo[WIDTH-1:1]};
        end
`ifdef ALU_SEQ_DIV_EN
        w_shift = {r_hi, r_lo[WIDTH-1]};
        w_sub   = w_shift[WIDTH-1:0] - r_m;
        if (w_op_div) begin
            if (w_shift >= {1'b0, r_m}) begin
                w_hi_nx = w_sub;
                w_lo_nx = {r_lo[WIDTH-2:0], 1'b1};
            end else begin
                w_hi_nx = w_shift[WIDTH-1:0];
                w_lo_nx = {r_lo[WIDTH-2:0], 1'b0};
            end
        end
`endif
        w_fin     = (r_op == OpMulhu || (w_op_div && r_op[0] == 1'b0)) ? w_hi_nx : w_lo_nx;
        w_fin_dbz = w_op_div && (r_m == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StIdle;
            r_out_valid <= 1'b0;
            r_res       <= '0;
            r_zero      <= 1'b1;
            r_ovf       <= 1'b0;
            r_dbz       <= 1'b0;
            r_hi        <= '0;
            r_lo        <= '0;
            r_m         <= '0;
            r_op        <= '0;
            r_cnt       <= '0;
        end else begin
            case (r_state)
                StIdle, StDone: begin
                    if (w_accept && w_multi) begin
                        r_state     <= StBusy;
                        r_out_valid <= 1'b0;
                        r_op        <= ALU_operation;
                        r_cnt       <= '0;
                        r_hi        <= '0;
                        r_m         <= w_in_div ? B : A;
                        r_lo        <= w_in_div ? A : B;
                    end else if (w_accept) begin
                        r_state     <= StDone;
                        r_out_valid <= 1'b1;
                        r_res       <= w_res;
                        r_zero      <= (w_res == '0);
                        r_ovf       <= w_ovf;
                        r_dbz       <= 1'b0;
                    end else if (r_state == StDone && out_ready) begin
                        r_state     <= StIdle;
                        r_out_valid <= 1'b0;
                    end
                end
                StBusy: begin
                    r_hi  <= w_hi_nx;
                    r_lo  <= w_lo_nx;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == SW'(WIDTH - 1)) begin
                        r_state     <= StDone;
                        r_out_valid <= 1'b1;
                        r_res       <= w_fin;
                        r_zero      <= (w_fin == '0);
                        r_ovf       <= 1'b0;
                        r_dbz       <= w_fin_dbz;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_seq.sv
// Randomised self-checking bench for alu_seq against a plain-arithmetic reference model.
module tb_alu_seq;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b1;
    logic [W-1:0] a_in = '0, b_in = '0;
    logic [3:0]   op_in = '0;
    logic         in_ready, out_valid, zero, ovf, dbz;
    logic [W-1:0] res;
    int           n_chk = 0, n_pass = 0;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(W), .SHAMT_LSB(6)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .A(a_in), .B(b_in), .ALU_operation(op_in), .out_valid(out_valid),
        .out_ready(out_ready), .res(res), .zero(zero), .ovf(ovf), .dbz(dbz)
    );

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic void model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] r, output logic o, output logic d,
                                  output int lat);
        int          sh;
        longint      s;
        logic [63:0] p;
        sh = int'(b[10:6]);
        p  = {32'b0, a} * {32'b0, b};
        r  = '0; o = 1'b0; d = 1'b0; lat = 1;
        case (op)
            4'd0:  r = a & b;
            4'd1:  r = a | b;
            4'd2: begin
                s = longint'($signed(a)) + longint'($signed(b));
                r = a + b;
                o = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'd3:  r = a ^ b;
            4'd4:  r = ~(a | b);
            4'd5:  r = a >> sh;
            4'd6: begin
                s = longint'($signed(a)) - longint'($signed(b));
                r = a - b;
                o = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'd7:  r = ($signed(a) < $signed(b)) ? 1 : 0;
            4'd8:  r = a << sh;
            4'd9:  r = $signed(a) >>> sh;
            4'd10: r = (a < b) ? 1 : 0;
            4'd11: begin r = p[31:0];  lat = W + 1; end
            4'd12: begin r = p[63:32]; lat = W + 1; end
`ifdef ALU_SEQ_DIV_EN
            4'd13: begin r = (b == 0) ? '1 : a / b; d = (b == 0); lat = W + 1; end
            4'd14: begin r = (b == 0) ? a : a % b; d = (b == 0); lat = W + 1; end
`endif
            default: r = '0;
        endcase
    endfunction

    task automatic run_op(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b);
        logic [W-1:0] er;
        logic         eo, ed;
        int           el, cyc;
        bit           rdy_bad;
        model(op, a, b, er, eo, ed, el);
        @(negedge clk);
        op_in = op; a_in = a; b_in = b; in_valid = 1'b1;
        chk({tag, "/in_ready"}, W'(in_ready), 1);
        @(negedge clk);
        in_valid = 1'b0;
        cyc = 1; rdy_bad = 0;
        while (!out_valid && cyc < 100) begin
            if (in_ready) rdy_bad = 1;
            @(negedge clk);
            cyc++;
        end
        chk({tag, "/latency"}, W'(cyc), W'(el));
        chk({tag, "/res"}, res, er);
        chk({tag, "/zero"}, W'(zero), W'(er == 0));
        chk({tag, "/ovf"}, W'(ovf), W'(eo));
        chk({tag, "/dbz"}, W'(dbz), W'(ed));
        if (el > 1) chk({tag, "/busy_ready"}, W'(rdy_bad), 0);
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        bit           seen;

        #12;
        chk("rst/out_valid", W'(out_valid), 0);
        chk("rst/res", res, 0);
        chk("rst/zero", W'(zero), 1);
        chk("rst/flags", W'({ovf, dbz}), 0);
        chk("rst/in_ready", W'(in_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("add_ovf", 4'd2, 32'h7FFFFFFF, 32'h1);
        chk("add_ovf/const", res, 32'h80000000);
        run_op("sub_eq", 4'd6, 32'd5, 32'd5);
        chk("sub_eq/zero_const", W'(zero), 1);
        run_op("sra", 4'd9, 32'h80000000, 32'h00000100);
        chk("sra/const", res, 32'hF8000000);
        run_op("slt", 4'd7, 32'hFFFFFFFF, 32'h1);
        run_op("sltu", 4'd10, 32'hFFFFFFFF, 32'h1);
        run_op("mul", 4'd11, 32'hFFFFFFFF, 32'h2);
        chk("mul/const", res, 32'hFFFFFFFE);
        run_op("mulhu", 4'd12, 32'hFFFFFFFF, 32'h2);
        chk("mulhu/const", res, 32'h1);
        run_op("divu", 4'd13, 32'd100, 32'd7);
        run_op("remu", 4'd14, 32'd100, 32'd7);
        run_op("divu0", 4'd13, 32'h1234, 32'd0);
        run_op("remu0", 4'd14, 32'h1234, 32'd0);
        run_op("rsvd", 4'd15, 32'h5, 32'h9);

        // Async reset in the middle of a multiply: outputs clear at once, no result follows.
        run_op("pre_rst", 4'd2, 32'd3, 32'd4);
        @(negedge clk);
        op_in = 4'd11; a_in = 32'd5; b_in = 32'd6; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst/out_valid", W'(out_valid), 0);
        chk("midrst/res", res, 0);
        chk("midrst/zero", W'(zero), 1);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("midrst/in_ready", W'(in_ready), 1);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) seen = 1;
        end
        chk("midrst/no_result", W'(seen), 0);

        // Backpressure, then release while a new ADD is waiting.
        out_ready = 1'b0;
        @(negedge clk);
        op_in = 4'd2; a_in = 32'd10; b_in = 32'd20; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp/out_valid", W'(out_valid), 1);
        repeat (5) begin
            @(negedge clk);
            chk("bp/res_hold", res, 32'd30);
            chk("bp/in_ready", W'(in_ready), 0);
            chk("bp/valid_hold", W'(out_valid), 1);
        end
        op_in = 4'd2; a_in = 32'd1; b_in = 32'd2; in_valid = 1'b1; out_ready = 1'b1;
        #1 chk("b2b/in_ready", W'(in_ready), 1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("b2b/out_valid", W'(out_valid), 1);
        chk("b2b/res", res, 32'd3);

        for (int i = 0; i < 150; i++) begin
            ra = (i % 3 == 0) ? W'($urandom_range(0, 400)) : W'($urandom);
            rb = (i % 4 == 0) ? W'($urandom_range(0, 20)) : W'($urandom);
            if (i % 17 == 0) rb = '0;
            run_op("rand", 4'($urandom_range(0, 15)), ra, rb);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
